hazard_forward_ctrl: RTL

- Sequencing controller for the RV32I 5-stage pipeline (F/D/E/M/W).
- Tracks the register fields of in-flight instructions in internal stage records and drives the 2-bit select codes of the EX-stage operand forwarding muxes.
- Generates the stall and flush controls for load-use hazards, taken branches and slow data memory.
- Counts stall cycles for performance monitoring.

---
 rtl/riscv_pkg.sv | 43 ++++
 rtl/fwd_sel_unit.sv | 32 +++
 rtl/hazard_forward_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I pipeline sequencing logic: forwarding
// select codes, hazard FSM states and the in-flight stage record layouts.
package riscv_pkg;

   localparam int REG_AW = 5;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      RUN,
      LU_STALL,
      MEM_WAIT
   } ctrl_state_e;

   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic              use1;
      logic              use2;
      logic [REG_AW-1:0] rd;
      logic              rw;
      logic              mr;
      logic              mw;
   } ex_rec_t;

   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] rd;
      logic              rw;
      logic              mr;
      logic              mw;
   } mem_rec_t;

   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] rd;
      logic              rw;
   } wb_rec_t;

endpackage

// File: rtl/fwd_sel_unit.sv
// Operand forwarding select for one EX source register. The MEM-stage
// producer is younger than the WB one, so it wins; loads in MEM have no
// data yet and x0 is hard-wired, so neither is ever forwarded.
module fwd_sel_unit
   import riscv_pkg::*;
(
   input  logic              e_valid,
   input  logic              src_used,
   input  logic [REG_AW-1:0] src_reg,
   input  logic              m_valid,
   input  logic              m_regwrite,
   input  logic              m_memread,
   input  logic [REG_AW-1:0] m_rd,
   input  logic              w_valid,
   input  logic              w_regwrite,
   input  logic [REG_AW-1:0] w_rd,
   output logic [1:0]        sel
);

   // Pick the youngest in-flight producer of the source register
   always_comb begin
      sel = FWD_REG;
      if (e_valid && src_used && (src_reg != '0)) begin
         if (m_valid && m_regwrite && !m_memread && (m_rd == src_reg)) begin
            sel = FWD_MEM;
         end else if (w_valid && w_regwrite && (w_rd == src_reg)) begin
            sel = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Sequencing controller for the 5-stage RV32I pipeline: tracks register
// fields of in-flight instructions, drives EX forwarding selects and
// generates stall/flush controls for load-use, taken branches and slow
// data memory. Also counts front-end stall cycles.
module hazard_forward_ctrl
   import riscv_pkg::*;
#(
   parameter int RA_W  = REG_AW,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_d,
   input  logic [RA_W-1:0]  rs1_d,
   input  logic [RA_W-1:0]  rs2_d,
   input  logic             use_rs1_d,
   input  logic             use_rs2_d,
   input  logic [RA_W-1:0]  rd_d,
   input  logic             regwrite_d,
   input  logic             memread_d,
   input  logic             memwrite_d,
   input  logic             branch_taken_e,
   input  logic             mem_ready,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             stall_f,
   output logic             stall_d,
   output logic             stall_e,
   output logic             stall_m,
   output logic             flush_d,
   output logic             flush_e,
   output logic [CNT_W-1:0] stall_count
);

   ex_rec_t     e_q;
   mem_rec_t    m_q;
   wb_rec_t     w_q;
   ctrl_state_e state_q, state_d;

   logic memwait;
   logic loaduse;
   logic branch_go;

   // Raw hazard conditions; the branch is masked during reset so every output reads 0
   always_comb begin
      memwait   = m_q.v && (m_q.mr || m_q.mw) && !mem_ready;
      loaduse   = valid_d && e_q.v && e_q.mr && (e_q.rd != '0) &&
                  ((use_rs1_d && (rs1_d == e_q.rd)) || (use_rs2_d && (rs2_d == e_q.rd)));
      branch_go = branch_taken_e && rst_n;
   end

   // Stall/flush controls with priority memwait > branch > load-use
   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      if (memwait) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
      end else if (branch_go) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (loaduse) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
      end
   end

   // Hazard FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (memwait) begin
               state_d = MEM_WAIT;
            end else if (loaduse && !branch_go) begin
               state_d = LU_STALL;
            end
         end
         LU_STALL: state_d = RUN;
         MEM_WAIT: begin
            if (!memwait) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Hazard FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Stage records: hold E/M and bubble WB on memory wait, otherwise shift D->E->M->W
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else if (memwait) begin
         w_q.v <= 1'b0;
      end else begin
         w_q.v  <= m_q.v;
         w_q.rd <= m_q.rd;
         w_q.rw <= m_q.rw;
         m_q.v  <= e_q.v;
         m_q.rd <= e_q.rd;
         m_q.rw <= e_q.rw;
         m_q.mr <= e_q.mr;
         m_q.mw <= e_q.mw;
         if (branch_go || loaduse) begin
            e_q.v <= 1'b0;
         end else begin
            e_q.v    <= valid_d;
            e_q.rs1  <= rs1_d;
            e_q.rs2  <= rs2_d;
            e_q.use1 <= use_rs1_d;
            e_q.use2 <= use_rs2_d;
            e_q.rd   <= rd_d;
            e_q.rw   <= regwrite_d;
            e_q.mr   <= memread_d;
            e_q.mw   <= memwrite_d;
         end
      end
   end

   // Performance counter of front-end stall cycles, wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
      end else if (stall_f) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

   fwd_sel_unit u_fwd_a (
      .e_valid    (e_q.v),
      .src_used   (e_q.use1),
      .src_reg    (e_q.rs1),
      .m_valid    (m_q.v),
      .m_regwrite (m_q.rw),
      .m_memread  (m_q.mr),
      .m_rd       (m_q.rd),
      .w_valid    (w_q.v),
      .w_regwrite (w_q.rw),
      .w_rd       (w_q.rd),
      .sel        (fwd_a_sel)
   );

   fwd_sel_unit u_fwd_b (
      .e_valid    (e_q.v),
      .src_used   (e_q.use2),
      .src_reg    (e_q.rs2),
      .m_valid    (m_q.v),
      .m_regwrite (m_q.rw),
      .m_memread  (m_q.mr),
      .m_rd       (m_q.rd),
      .w_valid    (w_q.v),
      .w_regwrite (w_q.rw),
      .w_rd       (w_q.rd),
      .sel        (fwd_b_sel)
   );

   // The load-use stall guarantees a load in MEM never feeds an operand in EX
   a_no_load_in_mem_consumer : assert property (@(posedge clk) disable iff (!rst_n)
      !(e_q.v && m_q.v && m_q.mr && (m_q.rd != '0) &&
        ((e_q.use1 && (e_q.rs1 == m_q.rd)) || (e_q.use2 && (e_q.rs2 == m_q.rd)))));

endmodule
